// File: rtl/i2c_rx_deserializer.sv
// i2c_rx_deserializer: oversampled I2C byte receiver that pushes bytes into the RX FIFO and drives ACK/NACK.
module i2c_rx_deserializer #(
  parameter int DATASIZE    = 8,
  parameter bit ALMOST_NACK = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                scl_i,
  input  logic                sda_i,
  input  logic                rx_en_i,
  input  logic                last_byte_i,
  input  logic                clr_ovf_i,
  input  logic                wfull_i,
  input  logic                w_almost_full_i,
  output logic [DATASIZE-1:0] wdata_o,
  output logic                winc_o,
  output logic                sda_drive_o,
  output logic                byte_done_o,
  output logic                nack_o,
  output logic                overflow_o,
  output logic                busy_o
);
  localparam int CW = $clog2(DATASIZE + 1);
  typedef enum logic [2:0] {IDLE, SHIFT, PUSH, ACK_SETUP, ACK_HOLD} state_t;
  state_t state;
  logic [1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det, abort;
  logic [DATASIZE-1:0] shreg;
  logic [CW-1:0] bit_cnt;
  logic ack;
  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;
  assign abort     = (state != IDLE) & (start_det | stop_det);
  // synchronisers reset high so an idle bus produces no spurious edges
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overflow_o <= 1'b0;
    else overflow_o <= (state == PUSH & ~abort & wfull_i) | (overflow_o & ~clr_ovf_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      ack         <= 1'b0;
      wdata_o     <= '0;
      winc_o      <= 1'b0;
      sda_drive_o <= 1'b0;
      byte_done_o <= 1'b0;
      nack_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      winc_o      <= 1'b0;
      byte_done_o <= 1'b0;
      nack_o      <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        sda_drive_o <= 1'b0;
        busy_o      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rx_en_i) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            busy_o  <= 1'b1;
          end
          SHIFT: if (scl_rise) begin
            shreg   <= {shreg[DATASIZE-2:0], sda_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DATASIZE - 1)) state <= PUSH;
          end
          PUSH: begin
            winc_o      <= ~wfull_i;
            wdata_o     <= wfull_i ? wdata_o : shreg;
            byte_done_o <= 1'b1;
            ack         <= ~last_byte_i & ~wfull_i & ~(ALMOST_NACK & w_almost_full_i);
            state       <= ACK_SETUP;
          end
          ACK_SETUP: if (scl_fall) begin
            sda_drive_o <= ack;
            state       <= ACK_HOLD;
          end
          ACK_HOLD: if (scl_fall) begin
            sda_drive_o <= 1'b0;
            nack_o      <= ~ack;
            bit_cnt     <= '0;
            state       <= (rx_en_i & ack) ? SHIFT : IDLE;
            busy_o      <= rx_en_i & ack;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_rx_deserializer.sv
// tb_i2c_rx_deserializer: drives I2C byte reads (directed + random) and checks against a byte-level model.
module tb_i2c_rx_deserializer;
  localparam bit AN = 1'b1;
  logic clk = 0, rst_n = 0, scl = 1, sda_tx = 1, rx_en = 0, last_byte = 0, clr_ovf = 0, wfull = 0, afull = 0;
  logic [7:0] wdata;
  logic winc, sda_drive, byte_done, nack, overflow, busy, sda_line;
  int n_checks = 0, n_errors = 0, winc_n = 0, bd_n = 0, nack_n = 0;
  logic [7:0] wq[$];
  logic ovf_m = 0;
  logic [7:0] last_w = 0;
  assign sda_line = sda_tx & ~sda_drive;
  always #5 clk = ~clk;
  i2c_rx_deserializer #(.DATASIZE(8), .ALMOST_NACK(AN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scl_i(scl), .sda_i(sda_line), .rx_en_i(rx_en),
    .last_byte_i(last_byte), .clr_ovf_i(clr_ovf), .wfull_i(wfull), .w_almost_full_i(afull),
    .wdata_o(wdata), .winc_o(winc), .sda_drive_o(sda_drive), .byte_done_o(byte_done),
    .nack_o(nack), .overflow_o(overflow), .busy_o(busy)
  );
  always @(negedge clk) begin
    if (winc) begin
      winc_n++;
      wq.push_back(wdata);
    end
    if (byte_done) bd_n++;
    if (nack) nack_n++;
  end
  initial begin
    #900000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    wait_n(5); sda_tx = b; wait_n(5); scl = 1; wait_n(10); scl = 0;
  endtask
  task automatic i2c_start();
    if (!scl) begin
      wait_n(5); sda_tx = 1; wait_n(5); scl = 1;
    end
    wait_n(10); sda_tx = 0; wait_n(10); scl = 0;
  endtask
  task automatic i2c_stop();
    wait_n(5); sda_tx = 0; wait_n(5); scl = 1; wait_n(10); sda_tx = 1; wait_n(10);
  endtask
  task automatic clr_pulse();
    wait_n(1); clr_ovf = 1; wait_n(1); clr_ovf = 0; wait_n(1);
    ovf_m = 0;
    check("ovf_clr", overflow, ovf_m);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic last, input logic full, input logic af,
                           input logic clr_push, input int drop_at);
    int w0, b0, n0;
    logic ack_e, drv;
    w0 = winc_n; b0 = bd_n; n0 = nack_n;
    last_byte = last; wfull = full; afull = af;
    ack_e = !last && !full && !(AN && af);
    for (int i = 7; i >= 0; i--) begin
      if (7 - i == drop_at) rx_en = 0;
      if (i == 0 && clr_push) begin
        wait_n(5); sda_tx = b[0]; wait_n(5); scl = 1;
        wait_n(3); clr_ovf = 1; wait_n(1); clr_ovf = 0; wait_n(6); scl = 0;
      end else send_bit(b[i]);
    end
    wait_n(5); sda_tx = 1; wait_n(5); scl = 1; wait_n(5); drv = sda_drive; wait_n(5); scl = 0; wait_n(6);
    ovf_m = full | (ovf_m & ~clr_push);
    if (!full) last_w = b;
    check("winc_cnt", winc_n - w0, {31'd0, !full});
    if (!full) begin
      if (wq.size() > 0) check("wdata_pushed", wq.pop_front(), b);
      else check("wdata_missing", 0, 1);
    end
    check("wdata_hold", wdata, last_w);
    check("byte_done_cnt", bd_n - b0, 1);
    check("ack_drive", drv, ack_e);
    check("nack_cnt", nack_n - n0, {31'd0, !ack_e});
    check("sda_release", sda_drive, 0);
    check("overflow", overflow, ovf_m);
  endtask
  initial begin
    int nb, w0, b0;
    logic [7:0] b;
    logic full, af, ack;
    wait_n(3);
    check("rst_winc", winc, 0);
    check("rst_wdata", wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_drive", sda_drive, 0);
    rst_n = 1;
    wait_n(3);
    check("idle_busy", busy, 0);
    check("idle_ovf", overflow, 0);
    check("idle_flags", {byte_done, nack, winc}, 0);
    rx_en = 1;
    wait_n(2);
    check("en_busy", busy, 1);
    i2c_start();
    send_byte(8'hA5, 0, 0, 0, 0, 8);
    check("a5_busy", busy, 1);
    send_byte(8'h3C, 0, 0, 0, 0, 8);
    send_byte(8'hC3, 1, 0, 0, 0, 4);
    check("last_busy", busy, 0);
    i2c_stop();
    check("stop_busy", busy, 0);
    rx_en = 1;
    i2c_start();
    send_byte(8'hFF, 0, 1, 0, 0, 8);
    i2c_stop();
    clr_pulse();
    i2c_start();
    send_byte(8'hFF, 0, 1, 0, 1, 8);
    i2c_stop();
    clr_pulse();
    i2c_start();
    w0 = winc_n; b0 = bd_n;
    last_byte = 0; wfull = 0; afull = 0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    i2c_stop();
    check("abort_winc", winc_n - w0, 0);
    check("abort_bd", bd_n - b0, 0);
    i2c_start();
    send_byte(8'h81, 0, 0, 0, 0, 8);
    i2c_stop();
    i2c_start();
    send_byte(8'h55, 0, 0, 1, 0, 8);
    i2c_stop();
    repeat (12) begin
      if ($urandom_range(0, 3) == 0) clr_pulse();
      rx_en = 1;
      i2c_start();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom);
        full = ($urandom_range(0, 5) == 0);
        af = ($urandom_range(0, 3) == 0);
        ack = !(k == nb - 1) && !full && !(AN && af);
        send_byte(b, k == nb - 1, full, af, 0, 8);
        if (!ack) break;
      end
      i2c_stop();
    end
    rx_en = 1;
    i2c_start();
    send_byte(8'hC7, 0, 1, 0, 0, 8);
    last_byte = 0; wfull = 0; afull = 0;
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    wait_n(5); sda_tx = 1; wait_n(5); scl = 1; wait_n(5);
    check("mid_drive", sda_drive, 1);
    check("mid_busy", busy, 1);
    check("mid_ovf", overflow, 1);
    rst_n = 0;
    #1;
    check("mrst_drive", sda_drive, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ovf", overflow, 0);
    check("mrst_wdata", wdata, 0);
    check("mrst_winc", winc, 0);
    wait_n(3);
    rst_n = 1;
    wait_n(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
